// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and the decoder
// that produces its per-instruction qualifiers.
package pipe_ctrl_pkg;

    // Branch-shadow controller states.
    typedef enum logic {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } state_t;

    // RV32 major opcodes the decoder uses to derive the hazard qualifiers.
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam int NUM_REGS = 32;

    // Qualifiers presented to pipe_ctrl alongside the register indices.
    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
        logic reg_write;
        logic is_ctrl;
    } id_quals_t;

    // Reference decode of the qualifiers for the opcode classes listed above;
    // everything else is treated as a register-register ALU op.
    function automatic id_quals_t decode_quals(input logic [6:0] opcode);
        id_quals_t q;
        q = '{rs1_used: 1'b1, rs2_used: 1'b1, reg_write: 1'b1, is_ctrl: 1'b0};
        case (opcode)
            OP_BRANCH: q = '{rs1_used: 1'b1, rs2_used: 1'b1, reg_write: 1'b0, is_ctrl: 1'b1};
            OP_JAL:    q = '{rs1_used: 1'b0, rs2_used: 1'b0, reg_write: 1'b1, is_ctrl: 1'b1};
            OP_LOAD:   q = '{rs1_used: 1'b1, rs2_used: 1'b0, reg_write: 1'b1, is_ctrl: 1'b0};
            OP_IMM:    q = '{rs1_used: 1'b1, rs2_used: 1'b0, reg_write: 1'b1, is_ctrl: 1'b0};
            OP_STORE:  q = '{rs1_used: 1'b1, rs2_used: 1'b1, reg_write: 1'b0, is_ctrl: 1'b0};
            default:   ;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decoder/writeback event bundle in, pipeline-register controls out.
interface pipe_ctrl_if #(
    parameter int PERF_W = 16
);
    // ID-stage instruction
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [4:0]        id_rd;
    logic              id_reg_write;
    logic              id_is_ctrl;
    // Resolution / writeback events
    logic              ex_resolved;
    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    // Pipeline controls
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              stall_data;
    logic              stall_ctrl;
    logic [31:0]       pending_mask;
    logic [PERF_W-1:0] stall_cycles;

    // Decoder / pipeline side
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_ctrl, ex_resolved, wb_reg_write, wb_rd,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, stall_data,
               stall_ctrl, pending_mask, stall_cycles
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_ctrl, ex_resolved, wb_reg_write, wb_rd,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, stall_data,
               stall_ctrl, pending_mask, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_reg_scoreboard.sv
// Per-register count of in-flight writers with combinational RAW lookup.
// x0 is never tracked; a same-cycle writeback may satisfy a read when the
// register file is write-through.
module pipe_ctrl_reg_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic [4:0]  inc_rd,
    input  logic        dec,
    input  logic [4:0]  dec_rd,
    input  logic [4:0]  rs1,
    input  logic        rs1_used,
    input  logic [4:0]  rs2,
    input  logic        rs2_used,
    output logic        hz_rs1,
    output logic        hz_rs2,
    output logic [31:0] pending_mask
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NUM_REGS];

    // A read of rs waits while a writer is in flight, unless the last writer
    // is retiring into a write-through register file this very cycle.
    function automatic logic hazard(input logic [4:0] rs, input logic used);
        logic bypass;
        bypass = WB_BYPASS && dec && (dec_rd == rs) && (cnt[rs] == CNT_ONE);
        return used && (rs != 5'd0) && (cnt[rs] != '0) && !bypass;
    endfunction

    // Update every tracked counter; simultaneous inc and dec cancel.
    // NOTE: the counter array is control state, not data storage, so it is
    // reset like any other register -- a stale count would stall forever.
    // NOTE: state is written with <= so every counter sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc && inc_rd == 5'(r) && !(dec && dec_rd == 5'(r))) begin
                    if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + CNT_ONE;
                end else if (dec && dec_rd == 5'(r) && !(inc && inc_rd == 5'(r))) begin
                    if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Hazard lookup for both sources and the occupancy view.
    always_comb begin
        hz_rs1 = hazard(rs1, rs1_used);
        hz_rs2 = hazard(rs2, rs2_used);
        for (int r = 0; r < NUM_REGS; r++) pending_mask[r] = (cnt[r] != '0);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: stalls ID on RAW hazards,
// freezes fetch in the shadow of an unresolved branch/JAL, and counts stall
// cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1,
    parameter int PERF_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    state_t            state;
    state_t            state_nxt;
    logic              hz_rs1;
    logic              hz_rs2;
    logic              stall_data;
    logic              stall_ctrl;
    logic              issue;
    logic              inc;
    logic              dec;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic [PERF_W-1:0] stall_cycles;

    // Only a real instruction leaving ID with a non-x0 destination allocates.
    assign stall_data = bus.id_valid && (state == IDLE) && (hz_rs1 || hz_rs2);
    assign issue      = bus.id_valid && (state == IDLE) && !stall_data;
    assign inc        = issue && bus.id_reg_write && (bus.id_rd != 5'd0);
    assign dec        = bus.wb_reg_write && (bus.wb_rd != 5'd0);

    pipe_ctrl_reg_scoreboard #(
        .CNT_W     (CNT_W),
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .inc          (inc),
        .inc_rd       (bus.id_rd),
        .dec          (dec),
        .dec_rd       (bus.wb_rd),
        .rs1          (bus.id_rs1),
        .rs1_used     (bus.id_rs1_used),
        .rs2          (bus.id_rs2),
        .rs2_used     (bus.id_rs2_used),
        .hz_rs1       (hz_rs1),
        .hz_rs2       (hz_rs2),
        .pending_mask (bus.pending_mask)
    );

    // Branch-shadow state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and pipeline controls; the flush owns IF/ID during the shadow
    // and the PC reloads only in the resolve cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_nxt    = state;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall_ctrl   = 1'b0;
        case (state)
            IDLE: begin
                pc_en        = !stall_data;
                if_id_en     = !stall_data;
                id_ex_bubble = stall_data;
                if (issue && bus.id_is_ctrl) state_nxt = SHADOW;
            end
            SHADOW: begin
                stall_ctrl   = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                pc_en        = bus.ex_resolved;
                if (bus.ex_resolved) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating count of cycles lost to either stall source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((stall_data || stall_ctrl) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.stall_data   = stall_data;
    assign bus.stall_ctrl   = stall_ctrl;
    assign bus.stall_cycles = stall_cycles;

endmodule
